// File: rtl/i2c_slave_bit_engine.sv
// Responder-side I2C bit/byte engine: filtered SCL/SDA sampling, START/STOP detection,
// address match, write-byte receive with ACK, and read-byte transmit on open-drain SDA.
module i2c_slave_bit_engine #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic       ack_en,
  input  logic [7:0] tx_data,
  output logic       start_o,
  output logic       stop_o,
  output logic       addr_match,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       master_nack,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  // Line 0 = SCL, line 1 = SDA; both share the synchroniser + glitch filter.
  logic [1:0] w_pin;
  logic [1:0] w_filt;
  logic [1:0] w_filt_d;
  assign w_pin = {i2c_sda, i2c_scl};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       r_s1, r_s2, r_f, r_fd;
      logic [3:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1  <= 1'b1;
          r_s2  <= 1'b1;
          r_f   <= 1'b1;
          r_fd  <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_pin[gi];
          r_s2 <= r_s1;
          r_fd <= r_f;
          if (r_s2 == r_f) begin
            r_cnt <= '0;
          end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
            r_f   <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      end
      assign w_filt[gi]   = r_f;
      assign w_filt_d[gi] = r_fd;
    end
  endgenerate

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_sda      = w_filt[1];
  assign w_scl_rise = w_filt[0] & ~w_filt_d[0];
  assign w_scl_fall = ~w_filt[0] & w_filt_d[0];
  assign w_start    = w_filt_d[1] & ~w_filt[1] & w_filt[0];
  assign w_stop     = ~w_filt_d[1] & w_filt[1] & w_filt[0];

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_bit_done, w_bit_done_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_addr_match, w_addr_match_nxt;
  logic       r_rw, w_rw_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_master_nack, w_master_nack_nxt;
  logic       r_start, w_start_nxt;
  logic       r_stop, w_stop_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 3'd7;
      r_bit_done    <= 1'b0;
      r_shift       <= '0;
      r_sda_oe      <= 1'b0;
      r_addr_match  <= 1'b0;
      r_rw          <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_req      <= 1'b0;
      r_master_nack <= 1'b0;
      r_start       <= 1'b0;
      r_stop        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_bit_done    <= w_bit_done_nxt;
      r_shift       <= w_shift_nxt;
      r_sda_oe      <= w_sda_oe_nxt;
      r_addr_match  <= w_addr_match_nxt;
      r_rw          <= w_rw_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rx_valid    <= w_rx_valid_nxt;
      r_tx_req      <= w_tx_req_nxt;
      r_master_nack <= w_master_nack_nxt;
      r_start       <= w_start_nxt;
      r_stop        <= w_stop_nxt;
    end
  end

  // Bits are counted on SCL rise so the SCL fall that follows START is not mistaken for a bit.
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_bit_done_nxt    = r_bit_done;
    w_shift_nxt       = r_shift;
    w_sda_oe_nxt      = r_sda_oe;
    w_addr_match_nxt  = r_addr_match;
    w_rw_nxt          = r_rw;
    w_rx_data_nxt     = r_rx_data;
    w_rx_valid_nxt    = 1'b0;
    w_tx_req_nxt      = 1'b0;
    w_master_nack_nxt = 1'b0;
    w_start_nxt       = 1'b0;
    w_stop_nxt        = 1'b0;
    if (w_start) begin
      w_state_nxt      = S_ADDR;
      w_bit_cnt_nxt    = 3'd7;
      w_bit_done_nxt   = 1'b0;
      w_addr_match_nxt = 1'b0;
      w_sda_oe_nxt     = 1'b0;
      w_start_nxt      = 1'b1;
    end else if (w_stop) begin
      w_state_nxt      = S_IDLE;
      w_addr_match_nxt = 1'b0;
      w_sda_oe_nxt     = 1'b0;
      w_stop_nxt       = 1'b1;
    end else begin
      case (r_state)
        S_ADDR, S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            if (r_bit_cnt == 3'd0) w_bit_done_nxt = 1'b1;
            else                   w_bit_cnt_nxt  = r_bit_cnt - 3'd1;
          end else if (w_scl_fall && r_bit_done) begin
            if (r_state == S_WR_DATA) begin
              w_state_nxt  = S_WR_ACK;
              w_sda_oe_nxt = ack_en;
            end else if (r_shift[7:1] == DEV_ADDR) begin
              w_state_nxt      = S_ADDR_ACK;
              w_rw_nxt         = r_shift[0];
              w_addr_match_nxt = 1'b1;
              w_sda_oe_nxt     = 1'b1;
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_rise) begin
            w_tx_req_nxt = r_rw;
          end else if (w_scl_fall) begin
            w_bit_cnt_nxt  = 3'd7;
            w_bit_done_nxt = 1'b0;
            if (r_rw) begin
              w_state_nxt  = S_RD_DATA;
              w_shift_nxt  = tx_data;
              w_sda_oe_nxt = ~tx_data[7];
            end else begin
              w_state_nxt  = S_WR_DATA;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_rise) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_state_nxt    = S_WR_DATA;
            w_sda_oe_nxt   = 1'b0;
            w_bit_cnt_nxt  = 3'd7;
            w_bit_done_nxt = 1'b0;
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise) begin
            if (r_bit_cnt == 3'd0) w_bit_done_nxt = 1'b1;
            else                   w_bit_cnt_nxt  = r_bit_cnt - 3'd1;
          end else if (w_scl_fall) begin
            if (r_bit_done) begin
              w_state_nxt  = S_RD_ACK;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_tx_req_nxt = 1'b1;
            end else begin
              w_master_nack_nxt = 1'b1;
              w_state_nxt       = S_IGNORE;
            end
          end else if (w_scl_fall) begin
            w_state_nxt    = S_RD_DATA;
            w_shift_nxt    = tx_data;
            w_sda_oe_nxt   = ~tx_data[7];
            w_bit_cnt_nxt  = 3'd7;
            w_bit_done_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with rst releases the bus in the same instant reset is applied.
  assign i2c_sda     = (r_sda_oe && !rst) ? 1'b0 : 1'bz;
  assign start_o     = r_start;
  assign stop_o      = r_stop;
  assign addr_match  = r_addr_match;
  assign rw          = r_rw;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_req      = r_tx_req;
  assign master_nack = r_master_nack;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_bit_engine.sv
// Bench for i2c_slave_bit_engine: a bit-banged I2C master drives directed transfers;
// received/read bytes are checked through scoreboard queues.
module tb_i2c_slave_bit_engine;
  localparam int Q = 16;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       start_o, stop_o, addr_match, rw, rx_valid, tx_req, master_nack, busy;
  logic [7:0] rx_data;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_bit_engine dut (
    .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda(sda), .ack_en(ack_en), .tx_data(tx_data),
    .start_o(start_o), .stop_o(stop_o), .addr_match(addr_match), .rw(rw), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_req(tx_req), .master_nack(master_nack), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txreq = 0, n_mnack = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_mrx[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; hold(Q);
    scl = 1'b1;       hold(Q);
    m_sda_low = 1'b1; hold(Q);
    scl = 1'b0;       hold(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; hold(Q);
    scl = 1'b1;       hold(Q);
    m_sda_low = 1'b0; hold(Q);
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    m_sda_low = ~b; hold(Q);
    scl = 1'b1;     hold(Q);
    if (glitch) begin
      scl = 1'b0; hold(2);
      scl = 1'b1; hold(Q - 2);
    end else begin
      hold(Q);
    end
    scl = 1'b0; hold(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; hold(Q);
    scl = 1'b1;       hold(Q);
    b = sda;          hold(Q);
    scl = 1'b0;       hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack, 1'b0);
    m_sda_low = 1'b0;
  endtask

  always @(negedge clk) begin
    if (start_o)     n_start++;
    if (stop_o)      n_stop++;
    if (tx_req)      n_txreq++;
    if (master_nack) n_mnack++;
    if (rx_valid) begin
      n_rxv++;
      chk("rx_expected", 32'(exp_rx.size() > 0), 1);
      if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int s_start, s_stop, s_rxv, s_txreq, s_mnack;

    hold(4);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {start_o, stop_o, rx_valid, tx_req, master_nack}, 0);
    chk("rst_addr_match", addr_match, 0);
    chk("rst_rw", rw, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b0;
    hold(4);

    // master write A0, B1, DA
    s_stop = n_stop; s_rxv = n_rxv;
    i2c_start();
    chk("wr_busy", busy, 1);
    write_byte(8'hA0, -1, ack); chk("wr_addr_ack", ack, 0);
    chk("wr_addr_match", addr_match, 1);
    chk("wr_rw", rw, 0);
    exp_rx.push_back(8'hB1); write_byte(8'hB1, -1, ack); chk("wr_b1_ack", ack, 0);
    exp_rx.push_back(8'hDA); write_byte(8'hDA, -1, ack); chk("wr_da_ack", ack, 0);
    i2c_stop(); hold(Q);
    chk("wr_busy_end", busy, 0);
    chk("wr_stop_cnt", n_stop - s_stop, 1);
    chk("wr_rxv_cnt", n_rxv - s_rxv, 2);
    chk("wr_rx_drained", exp_rx.size(), 0);
    chk("wr_match_clr", addr_match, 0);

    // random read: A0, B1, rep-START, A1, read 5A with NACK
    tx_data = 8'h5A;
    s_start = n_start; s_txreq = n_txreq; s_mnack = n_mnack;
    i2c_start();
    write_byte(8'hA0, -1, ack); chk("rd_wa_ack", ack, 0);
    exp_rx.push_back(8'hB1); write_byte(8'hB1, -1, ack); chk("rd_sub_ack", ack, 0);
    i2c_start();
    write_byte(8'hA1, -1, ack); chk("rd_ra_ack", ack, 0);
    chk("rd_rw", rw, 1);
    exp_mrx.push_back(8'h5A);
    read_byte(d, 1'b1);
    chk("rd_data", d, exp_mrx.pop_front());
    i2c_stop(); hold(Q);
    chk("rd_sda_rel", sda, 1);
    chk("rd_start_cnt", n_start - s_start, 2);
    chk("rd_txreq_cnt", n_txreq - s_txreq, 1);
    chk("rd_mnack_cnt", n_mnack - s_mnack, 1);
    chk("rd_busy_end", busy, 0);

    // address mismatch
    s_rxv = n_rxv;
    i2c_start();
    write_byte(8'hA2, -1, ack); chk("mm_addr_nack", ack, 1);
    write_byte(8'h33, -1, ack); chk("mm_data_nack", ack, 1);
    chk("mm_addr_match", addr_match, 0);
    chk("mm_busy", busy, 1);
    i2c_stop(); hold(Q);
    chk("mm_rxv_cnt", n_rxv - s_rxv, 0);

    // ack_en = 0
    ack_en = 1'b0;
    i2c_start();
    write_byte(8'hA0, -1, ack); chk("ae_addr_ack", ack, 0);
    exp_rx.push_back(8'h77); write_byte(8'h77, -1, ack); chk("ae_data_nack", ack, 1);
    i2c_stop(); hold(Q);
    ack_en = 1'b1;
    chk("ae_rx_drained", exp_rx.size(), 0);

    // reset during a read of 00
    tx_data = 8'h00;
    i2c_start();
    write_byte(8'hA1, -1, ack); chk("rr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) begin
      read_bit(ack); chk("rr_bit", ack, 0);
    end
    m_sda_low = 1'b0; hold(Q);
    scl = 1'b1; hold(Q);
    chk("rr_sda_driven", sda, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_sda_released", sda, 1);
    chk("rr_busy", busy, 0);
    hold(4);
    rst = 1'b0; hold(Q);
    scl = 1'b0; hold(Q);
    i2c_start();
    write_byte(8'hA0, -1, ack); chk("rr_after_addr_ack", ack, 0);
    exp_rx.push_back(8'h55); write_byte(8'h55, -1, ack); chk("rr_after_data_ack", ack, 0);
    i2c_stop(); hold(Q);
    chk("rr_rx_drained", exp_rx.size(), 0);

    // SCL glitch inside a data bit
    i2c_start();
    write_byte(8'hA0, -1, ack); chk("gl_addr_ack", ack, 0);
    exp_rx.push_back(8'h3C); write_byte(8'h3C, 5, ack); chk("gl_data_ack", ack, 0);
    chk("gl_addr_match", addr_match, 1);
    i2c_stop(); hold(Q);
    chk("gl_rx_drained", exp_rx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
